// File: rtl/rc_pkg.sv
// Shared RC receiver definitions: meter FSM states, microsecond word width, servo range constants.
// Used by rc_pulse_meter, rc_pulse_gen and their interfaces.
package rc_pkg;

    typedef enum logic [1:0] {
        WAIT_LOW,
        IDLE,
        HIGH
    } rc_meter_state_t;

    localparam int RC_US_W      = 16;
    localparam int RC_PW_MIN    = 1000;
    localparam int RC_PW_MAX    = 2000;
    localparam int RC_PW_CENTER = 1500;

    function automatic int clk_per_us(input int sys_clk);
        return sys_clk / 1000000;
    endfunction

endpackage

// File: rtl/rc_pulse_meter_if.sv
// Receiver-pin-to-pulse-width bundle; master is the meter, slave the pin driver / width consumer.
interface rc_pulse_meter_if;
    import rc_pkg::*;

    logic               rc_in;
    logic [RC_US_W-1:0] pw;
    logic               pw_valid;
    logic               locked;
    logic               bad_pulse;
    logic               timeout;

    modport master (input rc_in, output pw, pw_valid, locked, bad_pulse, timeout);
    modport slave  (output rc_in, input pw, pw_valid, locked, bad_pulse, timeout);

endinterface

// File: rtl/rc_sync_edge.sv
// 2-FF synchronizer with registered level/rise/fall; rise/fall appear 3 cycles after din moves.
// No backpressure: single-bit streaming path.
module rc_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;

    // Chain is not reset so a pulse already high across reset is still seen as high afterwards.
    always_ff @(posedge clk) begin
        meta  <= din;
        sync  <= meta;
        level <= sync;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= sync & ~level;
            fall <= ~sync & level;
        end
    end

endmodule

// File: rtl/rc_pulse_meter.sv
// Measures RC pulse high time in us with range check, lock tracking and failsafe on silence.
// pw/pw_valid one cycle after the detected falling edge; no backpressure, strobes are single-cycle.
module rc_pulse_meter
    import rc_pkg::*;
#(
    parameter int SYS_CLK     = 50000000,
    parameter int MIN_US      = 800,
    parameter int MAX_US      = 2200,
    parameter int TIMEOUT_US  = 50000,
    parameter int FAILSAFE_US = RC_PW_CENTER,
    parameter int LOCK_COUNT  = 3
) (
    input  logic                clk,
    input  logic                rst,
    rc_pulse_meter_if.master    bus
);

    localparam int CLK_PER_US = clk_per_us(SYS_CLK);
    localparam int PS_W       = $clog2(CLK_PER_US);
    localparam int TO_W       = $clog2(TIMEOUT_US + 1);

    localparam logic [PS_W-1:0]    PS_LAST   = PS_W'(CLK_PER_US - 1);
    localparam logic [TO_W-1:0]    TO_LAST   = TO_W'(TIMEOUT_US);
    localparam logic [RC_US_W-1:0] W_MIN     = RC_US_W'(MIN_US);
    localparam logic [RC_US_W-1:0] W_MAX     = RC_US_W'(MAX_US);
    localparam logic [RC_US_W-1:0] W_FS      = RC_US_W'(FAILSAFE_US);
    localparam logic [RC_US_W-1:0] W_SAT     = '1;
    localparam logic [7:0]         GOOD_LOCK = 8'(LOCK_COUNT);

    logic lvl, rise, fall;

    rc_sync_edge u_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (bus.rc_in),
        .level (lvl),
        .rise  (rise),
        .fall  (fall)
    );

    rc_meter_state_t state, state_n;
    logic start, judge;

    always_ff @(posedge clk) begin
        if (rst) state <= WAIT_LOW;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        start   = 1'b0;
        judge   = 1'b0;
        case (state)
            WAIT_LOW: if (!lvl) state_n = IDLE;
            IDLE:     if (rise) begin start = 1'b1; state_n = HIGH; end
            HIGH:     if (fall) begin judge = 1'b1; state_n = IDLE; end
            default:  state_n = WAIT_LOW;
        endcase
    end

    logic [PS_W-1:0]    ps_cnt, us_cnt;
    logic [RC_US_W-1:0] width, width_n, pw_reg;
    logic [TO_W-1:0]    to_cnt, to_inc;
    logic [7:0]         good_cnt;
    logic               valid_reg, bad_reg, timeout_reg;
    logic               in_range, accept, reject, us_tick, to_hit;

    // The falling-edge cycle is itself counted, so the judged width is floor(H / CLK_PER_US).
    assign width_n  = (ps_cnt == PS_LAST && width != W_SAT) ? width + RC_US_W'(1) : width;
    assign in_range = (width_n >= W_MIN) && (width_n <= W_MAX);
    assign accept   = judge & in_range;
    assign reject   = judge & ~in_range;
    assign us_tick  = (us_cnt == PS_LAST);
    assign to_inc   = to_cnt + TO_W'(us_tick);
    assign to_hit   = (to_inc == TO_LAST) && !accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            ps_cnt      <= '0;
            us_cnt      <= '0;
            width       <= '0;
            to_cnt      <= '0;
            good_cnt    <= '0;
            pw_reg      <= W_FS;
            valid_reg   <= 1'b0;
            bad_reg     <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            valid_reg   <= accept;
            bad_reg     <= reject;
            timeout_reg <= to_hit;
            us_cnt      <= us_tick ? '0 : us_cnt + PS_W'(1);

            if (start) begin
                ps_cnt <= '0;
                width  <= '0;
            end else if (state == HIGH) begin
                ps_cnt <= (ps_cnt == PS_LAST) ? '0 : ps_cnt + PS_W'(1);
                width  <= width_n;
            end

            if (accept) begin
                pw_reg <= width_n;
                to_cnt <= '0;
                if (good_cnt != GOOD_LOCK) good_cnt <= good_cnt + 8'd1;
            end else begin
                to_cnt <= to_hit ? '0 : to_inc;
                if (to_hit)           pw_reg   <= W_FS;
                if (reject || to_hit) good_cnt <= '0;
            end
        end
    end

    assign bus.pw        = pw_reg;
    assign bus.pw_valid  = valid_reg;
    assign bus.bad_pulse = bad_reg;
    assign bus.timeout   = timeout_reg;
    assign bus.locked    = (good_cnt == GOOD_LOCK);

endmodule

// File: tb/tb_rc_pulse_meter.sv
// Directed bench for rc_pulse_meter, time-scaled: 4 clk per us, range 80..220 us, failsafe 150, timeout 1000 us.
module tb_rc_pulse_meter;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    rc_pulse_meter_if bus ();

    rc_pulse_meter #(
        .SYS_CLK     (4000000),
        .MIN_US      (80),
        .MAX_US      (220),
        .TIMEOUT_US  (1000),
        .FAILSAFE_US (150),
        .LOCK_COUNT  (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_valid, n_bad, n_to;
    int cyc = 0;
    int valid_cyc, fall_cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic clear();
        n_valid   = 0;
        n_bad     = 0;
        n_to      = 0;
        valid_cyc = 0;
    endtask

    // Advance n cycles, sampling strobes 1 ns after each rising edge.
    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.pw_valid === 1'b1) begin
                n_valid++;
                if (valid_cyc == 0) valid_cyc = cyc;
            end
            if (bus.bad_pulse === 1'b1) n_bad++;
            if (bus.timeout === 1'b1)   n_to++;
        end
    endtask

    task automatic pulse(input int hi, input int lo);
        clear();
        bus.rc_in = 1'b1;
        run(hi);
        bus.rc_in = 1'b0;
        fall_cyc = cyc;
        run(lo);
    endtask

    initial begin
        bus.rc_in = 1'b0;
        clear();

        // Reset state
        run(5);
        check("rst_pw", bus.pw, 150);
        check("rst_valid", bus.pw_valid, 0);
        check("rst_locked", bus.locked, 0);
        check("rst_bad", bus.bad_pulse, 0);
        check("rst_timeout", bus.timeout, 0);
        rst = 1'b0;
        run(10);

        // Accepted 150 us pulses, lock on the third
        for (int i = 0; i < 3; i++) begin
            pulse(600, 400);
            if (i == 0) check("latency", valid_cyc - fall_cyc, 4);
            check("lock_pw", bus.pw, 150);
            check("lock_nvalid", n_valid, 1);
            check("lock_locked", bus.locked, (i == 2) ? 1 : 0);
        end

        // Upper range edge
        pulse(880, 400);
        check("max_pw", bus.pw, 220);
        check("max_nvalid", n_valid, 1);
        pulse(883, 400);
        check("max_frac_pw", bus.pw, 220);
        check("max_frac_nvalid", n_valid, 1);
        pulse(884, 400);
        check("over_nbad", n_bad, 1);
        check("over_nvalid", n_valid, 0);
        check("over_pw", bus.pw, 220);
        check("over_locked", bus.locked, 0);

        // Lower range edge
        pulse(319, 400);
        check("under_nbad", n_bad, 1);
        check("under_pw", bus.pw, 220);
        pulse(320, 400);
        check("min_pw", bus.pw, 80);
        check("min_nvalid", n_valid, 1);

        // Short glitch while locked, then relock at 120 us
        for (int i = 0; i < 3; i++) pulse(600, 400);
        check("relock150_locked", bus.locked, 1);
        check("relock150_pw", bus.pw, 150);
        pulse(200, 400);
        check("glitch_nbad", n_bad, 1);
        check("glitch_pw", bus.pw, 150);
        check("glitch_locked", bus.locked, 0);
        for (int i = 0; i < 3; i++) begin
            pulse(480, 400);
            check("relock120_locked", bus.locked, (i == 2) ? 1 : 0);
        end
        check("relock120_pw", bus.pw, 120);

        // Silence after a 180 us pulse: failsafe, then a repeat 1000 us later
        pulse(720, 20);
        check("pre_silence_nvalid", n_valid, 1);
        check("pre_silence_pw", bus.pw, 180);
        check("pre_silence_locked", bus.locked, 1);
        clear();
        run(3900);
        check("silence_early_nto", n_to, 0);
        run(200);
        check("silence_nto1", n_to, 1);
        check("silence_pw", bus.pw, 150);
        check("silence_locked", bus.locked, 0);
        run(3800);
        check("silence_gap_nto", n_to, 1);
        run(200);
        check("silence_nto2", n_to, 2);

        // Stuck high for 2400 us
        clear();
        bus.rc_in = 1'b1;
        run(9600);
        check("stuck_nto", n_to, 2);
        check("stuck_nvalid", n_valid, 0);
        clear();
        bus.rc_in = 1'b0;
        run(20);
        check("stuck_release_nbad", n_bad, 1);
        check("stuck_release_pw", bus.pw, 150);

        // Reset 60 us into a 150 us pulse
        clear();
        bus.rc_in = 1'b1;
        run(240);
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        run(360);
        bus.rc_in = 1'b0;
        run(40);
        check("rstmid_nvalid", n_valid, 0);
        check("rstmid_nbad", n_bad, 0);
        check("rstmid_locked", bus.locked, 0);
        pulse(600, 100);
        check("after_rst_nvalid", n_valid, 1);
        check("after_rst_pw", bus.pw, 150);
        check("after_rst_nto", n_to, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
